imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time program loader that writes the instruction memory of the single-cycle RISC-V core. It consumes a byte stream (from the UART receiver or a testbench driver), assembles little-endian 32-bit instruction words, and drives the instruction-memory write port. It holds the core in reset until the program is fully written, then releases it so that `pc_out` starts fetching from `BASE_ADDR`.

## Interface
Parameters:
- `ADDR_W`, default 8: instruction-memory word-address width; depth is 2^ADDR_W words.
- `BASE_ADDR`, default 0: word address of the first loaded instruction.

Ports:
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `in_valid`  in  1: byte stream valid.
- `in_data`  in  8: byte stream data.
- `in_ready`  out  1: loader can accept a byte; a transfer occurs when `in_valid & in_ready` at a rising edge.
- `reload`  in  1: single-cycle pulse that restarts loading; honoured only in DONE or ERR.
- `imem_we`  out  1: instruction-memory write strobe, one cycle per word.
- `imem_addr`  out  ADDR_W: word address.
- `imem_wdata`  out  32: instruction word.
- `core_rst_n`  out  1: active-low reset to the datapath.
- `busy`  out  1: high while in LEN, DATA or CHK.
- `done`  out  1: high in DONE.
- `ovf`  out  1: sticky; a word index reached 2^ADDR_W − BASE_ADDR.
- `err`  out  1: sticky checksum mismatch. Tied to 0 when the checksum feature is compiled out.

## Operation
- Frame format: 2-byte word count N (little-endian), then N×4 payload bytes (each word LSB first), then an optional checksum byte (see Configuration).
- FSM states: LEN, DATA, CHK, DONE, ERR.
  - LEN: accept 2 bytes into `cnt[15:0]`. If N=0, go to CHK (checksum enabled) or DONE (checksum disabled). Otherwise go to DATA.
  - DATA: shift bytes into a 32-bit assembler with a 2-bit byte index. On the 4th byte, write the word and increment the word index. After word N, go to CHK or DONE.
  - CHK: accept 1 byte, compare it with the running checksum, then go to DONE on a match or ERR on a mismatch.
  - DONE, ERR: `in_ready`=0; input bytes are ignored.
- `imem_addr` = BASE_ADDR + word index, truncated to ADDR_W bits.
- Overflow: when BASE_ADDR + index ≥ 2^ADDR_W, the word is consumed but `imem_we` stays 0 and `ovf` sets. The frame still completes normally.
- `reload` in DONE or ERR:
  - Return to LEN.
  - Drive `core_rst_n` low.
  - Clear `ovf`, `err`, the checksum, the index and the byte count.
  - `reload` in any other state is ignored.

## Timing
- Reset values: state=LEN, `in_ready`=1, `imem_we`=0, `imem_addr`=BASE_ADDR, `imem_wdata`=0, `core_rst_n`=0, `busy`=1, `done`=0, `ovf`=0, `err`=0.
- `in_ready` is a registered state decode and is high in LEN, DATA and CHK. The loader accepts one byte per cycle with no internal bubbles.
- `imem_we`, `imem_addr` and `imem_wdata` are registered. They are valid in the cycle after the 4th byte of a word is accepted, and `imem_we` is high for exactly 1 cycle.
- `core_rst_n` is registered and rises 1 cycle after DONE is entered. It therefore rises no earlier than 1 cycle after the final `imem_we` pulse, so the core never fetches an unwritten word.
- `core_rst_n` falls 1 cycle after `reload` is accepted. It stays low permanently in ERR.
- Reset asserted mid-frame abandons the frame. The partially loaded memory is not cleared, and the core stays in reset until a full frame loads.
- The input stream may stall arbitrarily (`in_valid`=0). State is held during a stall and there is no timeout.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - The frame carries a trailing byte equal to the XOR of all preceding frame bytes, including the count bytes.
  - A mismatch goes to ERR, sets `err`, and keeps `core_rst_n` low.
- `IMEM_LOADER_CHECKSUM_EN` undefined:
  - The CHK state and the checksum register are absent.
  - The last payload byte goes directly to DONE.
  - `err` is tied to 0.

## Structure
- Shared package `imem_loader_pkg`:
  - State enum (LEN, DATA, CHK, DONE, ERR).
  - Byte-index width constant.
  - Frame header size constant (2).
- One natural sub-module: `byte_to_word`, a 4-byte little-endian assembler with a `word_valid` pulse. The FSM, counters and write-port registers stay in `imem_loader`.

## Test plan
- Load N=3 words 0x00500093, 0x00A00113, 0x002081B3 (bytes 03 00 93 00 50 00 …) with continuous `in_valid` → 3 `imem_we` pulses at addresses 0, 1, 2 with those words; `core_rst_n` rises 1 cycle after DONE; `done`=1.
- Same frame with `in_valid` toggling every other cycle → identical writes; no byte dropped or duplicated.
- N=0 → no `imem_we`; DONE reached and `core_rst_n`=1 (with the checksum enabled, after byte 0x00).
- BASE_ADDR=254, ADDR_W=8, N=3 → writes to 254 and 255 only; third word not written; `ovf`=1.
- With `IMEM_LOADER_CHECKSUM_EN`, a corrupted checksum byte → ERR; `err`=1; `core_rst_n` stays 0. A subsequent `reload` plus a correct frame → DONE, and `err` clears.
- `rst_n` pulsed after 5 payload bytes, then a full frame resent → loads correctly from address BASE_ADDR.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// ----------------------------------------------------------------------------
// imem_loader_pkg
// Shared types and constants for the boot-time instruction-memory loader.
//   state_t     : loader FSM states (LEN, DATA, CHK, DONE, ERR)
//   BYTE_IDX_W  : width of the byte-within-word index (4 bytes per word)
//   HDR_BYTES   : number of word-count bytes at the start of a frame
// ----------------------------------------------------------------------------
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_LEN  = 3'd0,
        ST_DATA = 3'd1,
        ST_CHK  = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    localparam int BYTE_IDX_W = 2;
    localparam int HDR_BYTES  = 2;

endpackage

// File: rtl/imem_loader_byte_to_word.sv
// ----------------------------------------------------------------------------
// byte_to_word
// Little-endian 4-byte assembler. The first byte of a word lands in bits
// [7:0]. word_valid is a combinational pulse in the cycle the 4th byte is
// presented, with word already holding the complete value, so the parent can
// register its write port directly from it.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear       : synchronous restart of the byte index
//   byte_valid  : a byte is consumed this cycle
//   byte_data   : the byte
//   word_valid  : 4th byte of a word is being consumed this cycle
//   word        : assembled 32-bit word (valid with word_valid)
// ----------------------------------------------------------------------------
module byte_to_word
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [BYTE_IDX_W-1:0] byte_idx;
    logic [23:0]           low_bytes;

    // The three earlier bytes sit in low_bytes; the current byte completes
    // the word without needing an extra register stage.
    assign word_valid = byte_valid && (byte_idx == {BYTE_IDX_W{1'b1}});
    assign word       = {byte_data, low_bytes};

    // Bytes shift in from the top so that after three bytes the oldest one
    // ends up in the least significant position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx  <= '0;
            low_bytes <= '0;
        end else if (clear) begin
            byte_idx  <= '0;
        end else if (byte_valid) begin
            low_bytes <= {byte_data, low_bytes[23:8]};
            byte_idx  <= byte_idx + 1'b1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// ----------------------------------------------------------------------------
// imem_loader
// Boot-time program loader for the single-cycle RISC-V core. Consumes a byte
// stream framed as: 2-byte little-endian word count N, N*4 payload bytes
// (each word LSB first), and, when IMEM_LOADER_CHECKSUM_EN is defined, one
// trailing XOR checksum byte over all preceding frame bytes. Words are written
// to instruction memory starting at BASE_ADDR; the core is held in reset
// until the whole program is in place.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (CHK state, err output).
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_data      : byte stream
//   in_ready              : loader accepts a byte (registered state decode)
//   reload                : restart loading, honoured in DONE or ERR only
//   imem_we/addr/wdata    : registered instruction-memory write port
//   core_rst_n            : active-low reset to the datapath
//   busy, done            : status (LEN/DATA/CHK, DONE)
//   ovf                   : sticky, a word fell beyond the end of memory
//   err                   : sticky checksum mismatch (0 without checksum)
// ----------------------------------------------------------------------------
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst_n,
    output logic              busy,
    output logic              done,
    output logic              ovf,
    output logic              err
);

    localparam logic [32:0] DEPTH = 33'd1 << ADDR_W;
    localparam int          HDR_IDX_W = (HDR_BYTES > 1) ? $clog2(HDR_BYTES) : 1;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t POST_PAYLOAD = ST_CHK;
`else
    localparam state_t POST_PAYLOAD = ST_DONE;
`endif

    state_t               state;
    state_t               state_next;
    logic [15:0]          cnt;
    logic [HDR_IDX_W-1:0] hdr_idx;
    logic [15:0]          word_idx;
    logic                 accept;
    logic                 hdr_last;
    logic [15:0]          len_full;
    logic                 last_word;
    logic                 reload_take;
    logic                 word_valid;
    logic [31:0]          word;
    logic [32:0]          abs_addr;
    logic                 word_ovf;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] chk;
    logic       chk_match;
    assign chk_match = (in_data == chk);
`endif

    assign accept      = in_valid && in_ready;
    assign hdr_last    = (32'(hdr_idx) == HDR_BYTES - 1);
    assign len_full    = {in_data, cnt[7:0]};
    assign last_word   = (word_idx == cnt - 16'd1);
    assign reload_take = reload && ((state == ST_DONE) || (state == ST_ERR));

    // The full-width address tells apart words that fit in memory from words
    // that wrap past the top; the write port only ever sees the truncation.
    assign abs_addr = 33'(BASE_ADDR) + {17'd0, word_idx};
    assign word_ovf = (abs_addr >= DEPTH);

    byte_to_word u_b2w (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (reload_take),
        .byte_valid (accept && (state == ST_DATA)),
        .byte_data  (in_data),
        .word_valid (word_valid),
        .word       (word)
    );

    // Next-state decode; the registered status outputs are derived from it so
    // they line up with the state register.
    always_comb begin
        state_next = state;
        case (state)
            ST_LEN: begin
                if (accept && hdr_last)
                    state_next = (len_full == 16'd0) ? POST_PAYLOAD : ST_DATA;
            end
            ST_DATA: begin
                if (word_valid && last_word)
                    state_next = POST_PAYLOAD;
            end
            ST_CHK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (accept)
                    state_next = chk_match ? ST_DONE : ST_ERR;
`else
                state_next = ST_DONE;
`endif
            end
            ST_DONE, ST_ERR: begin
                if (reload)
                    state_next = ST_LEN;
            end
            default: state_next = ST_LEN;
        endcase
    end

    // Main loader register block: state, counters, write port and status.
    // core_rst_n is only raised while sitting in DONE, which guarantees at
    // least one cycle between the last write strobe and the core leaving
    // reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_LEN;
            in_ready   <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            cnt        <= '0;
            hdr_idx    <= '0;
            word_idx   <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= ADDR_W'(BASE_ADDR);
            imem_wdata <= '0;
            core_rst_n <= 1'b0;
            ovf        <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk        <= '0;
            err        <= 1'b0;
`endif
        end else begin
            state    <= state_next;
            in_ready <= (state_next == ST_LEN) || (state_next == ST_DATA) ||
                        (state_next == ST_CHK);
            busy     <= (state_next == ST_LEN) || (state_next == ST_DATA) ||
                        (state_next == ST_CHK);
            done     <= (state_next == ST_DONE);
            imem_we  <= 1'b0;

            case (state)
                ST_LEN: begin
                    if (accept) begin
                        if (hdr_idx == '0)
                            cnt[7:0] <= in_data;
                        else
                            cnt[15:8] <= in_data;
                        hdr_idx <= hdr_last ? '0 : hdr_idx + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        chk <= chk ^ in_data;
`endif
                    end
                end
                ST_DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    if (accept)
                        chk <= chk ^ in_data;
`endif
                    // Words past the end of memory are still consumed so the
                    // frame stays in step; they just never strobe the memory.
                    if (word_valid) begin
                        imem_we    <= !word_ovf;
                        imem_addr  <= abs_addr[ADDR_W-1:0];
                        imem_wdata <= word;
                        word_idx   <= word_idx + 16'd1;
                        if (word_ovf)
                            ovf <= 1'b1;
                    end
                end
                ST_CHK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    if (accept && !chk_match)
                        err <= 1'b1;
`endif
                end
                ST_DONE, ST_ERR: begin
                    if (reload) begin
                        cnt        <= '0;
                        hdr_idx    <= '0;
                        word_idx   <= '0;
                        ovf        <= 1'b0;
                        core_rst_n <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        chk        <= '0;
                        err        <= 1'b0;
`endif
                    end else if (state == ST_DONE) begin
                        core_rst_n <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifndef IMEM_LOADER_CHECKSUM_EN
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// ----------------------------------------------------------------------------
// tb_imem_loader
// Directed bench for imem_loader. Two instances share one byte stream: one at
// BASE_ADDR=0 and one at BASE_ADDR=254 (ADDR_W=8) so every frame also covers
// the top-of-memory overflow case. Write strobes of each instance are logged
// on the falling edge and compared against hand-written expected words.
// ----------------------------------------------------------------------------
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        reload;

    logic        in_ready_a, imem_we_a, core_rst_n_a, busy_a, done_a, ovf_a, err_a;
    logic [7:0]  imem_addr_a;
    logic [31:0] imem_wdata_a;
    logic        in_ready_b, imem_we_b, core_rst_n_b, busy_b, done_b, ovf_b, err_b;
    logic [7:0]  imem_addr_b;
    logic [31:0] imem_wdata_b;

    int total = 0;
    int bad   = 0;

    logic [31:0] words [3];
    logic [7:0]  csum;

    logic [7:0]  log_addr_a [64];
    logic [31:0] log_data_a [64];
    int          wcnt_a = 0;
    int          mark_a;
    logic [7:0]  log_addr_b [64];
    logic [31:0] log_data_b [64];
    int          wcnt_b = 0;
    int          mark_b;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready_a),
        .reload     (reload),
        .imem_we    (imem_we_a),
        .imem_addr  (imem_addr_a),
        .imem_wdata (imem_wdata_a),
        .core_rst_n (core_rst_n_a),
        .busy       (busy_a),
        .done       (done_a),
        .ovf        (ovf_a),
        .err        (err_a)
    );

    imem_loader #(.ADDR_W(8), .BASE_ADDR(254)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready_b),
        .reload     (reload),
        .imem_we    (imem_we_b),
        .imem_addr  (imem_addr_b),
        .imem_wdata (imem_wdata_b),
        .core_rst_n (core_rst_n_b),
        .busy       (busy_b),
        .done       (done_b),
        .ovf        (ovf_b),
        .err        (err_b)
    );

    // Write loggers: every cycle the strobe is high adds one entry, so a
    // stretched or duplicated strobe shows up as an extra write.
    always @(negedge clk) begin
        if (imem_we_a) begin
            log_addr_a[wcnt_a % 64] <= imem_addr_a;
            log_data_a[wcnt_a % 64] <= imem_wdata_a;
            wcnt_a = wcnt_a + 1;
        end
    end

    always @(negedge clk) begin
        if (imem_we_b) begin
            log_addr_b[wcnt_b % 64] <= imem_addr_b;
            log_data_b[wcnt_b % 64] <= imem_wdata_b;
            wcnt_b = wcnt_b + 1;
        end
    end

    // Hard stop in case something goes badly wrong outside a bounded wait.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Presents one byte after 'gap' idle cycles and returns on the falling
    // edge following the rising edge that transferred it.
    task automatic applyStimulus(input logic [7:0] b, input int gap);
        int guard;
        for (int i = 0; i < gap; i++) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        guard    = 0;
        while (!in_ready_a && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 64) begin
            total++;
            bad++;
            $error("[TB] FAIL byte_accept_timeout: got in_ready=0, want 1");
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Count and payload only; returns the XOR of every byte sent.
    task automatic sendBody(input int n, input int gap, output logic [7:0] x);
        logic [15:0] len;
        logic [31:0] w;
        len = 16'(n);
        x   = 8'h00;
        applyStimulus(len[7:0], gap);
        x = x ^ len[7:0];
        applyStimulus(len[15:8], gap);
        x = x ^ len[15:8];
        for (int k = 0; k < n; k++) begin
            w = words[k];
            for (int b = 0; b < 4; b++) begin
                applyStimulus(w[8*b +: 8], gap);
                x = x ^ w[8*b +: 8];
            end
        end
        $display("[TB] sent frame n=%0d xor=%02h", n, x);
    endtask

    task automatic sendFrame(input int n, input int gap);
        sendBody(n, gap, csum);
`ifdef IMEM_LOADER_CHECKSUM_EN
        applyStimulus(csum, gap);
`endif
    endtask

    task automatic pulseReload();
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        checkOutput("reload_core_rst_low", 32'(core_rst_n_a), 32'd0);
        checkOutput("reload_ready", 32'(in_ready_a), 32'd1);
        checkOutput("reload_busy", 32'(busy_a), 32'd1);
        checkOutput("reload_done_clear", 32'(done_a), 32'd0);
        checkOutput("reload_ovf_clear", 32'(ovf_b), 32'd0);
        checkOutput("reload_err_clear", 32'(err_a), 32'd0);
    endtask

    // Called on the falling edge right after the final byte of a 3-word
    // frame was accepted.
    task automatic checkLoaded(input string tag);
        checkOutput({tag, "_done"}, 32'(done_a), 32'd1);
        checkOutput({tag, "_core_rst_held"}, 32'(core_rst_n_a), 32'd0);
        checkOutput({tag, "_ready_low"}, 32'(in_ready_a), 32'd0);
        checkOutput({tag, "_busy_low"}, 32'(busy_a), 32'd0);
        @(negedge clk);
        checkOutput({tag, "_core_rst_rise_a"}, 32'(core_rst_n_a), 32'd1);
        checkOutput({tag, "_core_rst_rise_b"}, 32'(core_rst_n_b), 32'd1);
        #1;
        checkOutput({tag, "_wr_count_a"}, 32'(wcnt_a - mark_a), 32'd3);
        for (int k = 0; k < 3; k++) begin
            checkOutput({tag, "_wr_addr_a"}, 32'(log_addr_a[(mark_a + k) % 64]), 32'(k));
            checkOutput({tag, "_wr_data_a"}, log_data_a[(mark_a + k) % 64], words[k]);
        end
        checkOutput({tag, "_wr_count_b"}, 32'(wcnt_b - mark_b), 32'd2);
        for (int k = 0; k < 2; k++) begin
            checkOutput({tag, "_wr_addr_b"}, 32'(log_addr_b[(mark_b + k) % 64]), 32'(254 + k));
            checkOutput({tag, "_wr_data_b"}, log_data_b[(mark_b + k) % 64], words[k]);
        end
        checkOutput({tag, "_ovf_a"}, 32'(ovf_a), 32'd0);
        checkOutput({tag, "_ovf_b"}, 32'(ovf_b), 32'd1);
        checkOutput({tag, "_err"}, 32'(err_a), 32'd0);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_ready"}, 32'(in_ready_a), 32'd1);
        checkOutput({tag, "_we"}, 32'(imem_we_a), 32'd0);
        checkOutput({tag, "_addr_a"}, 32'(imem_addr_a), 32'd0);
        checkOutput({tag, "_addr_b"}, 32'(imem_addr_b), 32'd254);
        checkOutput({tag, "_wdata"}, imem_wdata_a, 32'd0);
        checkOutput({tag, "_core_rst"}, 32'(core_rst_n_a), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy_a), 32'd1);
        checkOutput({tag, "_done"}, 32'(done_a), 32'd0);
        checkOutput({tag, "_ovf"}, 32'(ovf_b), 32'd0);
        checkOutput({tag, "_err"}, 32'(err_a), 32'd0);
    endtask

    initial begin
        logic [7:0] x;
        words[0] = 32'h00500093;
        words[1] = 32'h00A00113;
        words[2] = 32'h002081B3;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        reload   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkResetState("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back frame with three words.
        mark_a = wcnt_a;
        mark_b = wcnt_b;
        sendFrame(3, 0);
        checkLoaded("cont");

        // Bytes offered in DONE must be ignored.
        mark_a   = wcnt_a;
        in_valid = 1'b1;
        in_data  = 8'hAA;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        #1;
        checkOutput("done_ignores_bytes", 32'(wcnt_a - mark_a), 32'd0);
        checkOutput("done_holds", 32'(done_a), 32'd1);
        checkOutput("done_core_rst_high", 32'(core_rst_n_a), 32'd1);

        // Same frame with in_valid toggling every other cycle.
        pulseReload();
        mark_a = wcnt_a;
        mark_b = wcnt_b;
        sendFrame(3, 1);
        checkLoaded("stall");

        // Empty program.
        pulseReload();
        mark_a = wcnt_a;
        mark_b = wcnt_b;
        sendFrame(0, 0);
        checkOutput("empty_done", 32'(done_a), 32'd1);
        @(negedge clk);
        #1;
        checkOutput("empty_core_rst", 32'(core_rst_n_a), 32'd1);
        checkOutput("empty_no_writes_a", 32'(wcnt_a - mark_a), 32'd0);
        checkOutput("empty_no_writes_b", 32'(wcnt_b - mark_b), 32'd0);
        checkOutput("empty_ovf_b", 32'(ovf_b), 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Corrupted checksum lands in ERR and keeps the core in reset.
        pulseReload();
        sendBody(3, 0, x);
        applyStimulus(x ^ 8'hFF, 0);
        checkOutput("chk_err_set", 32'(err_a), 32'd1);
        checkOutput("chk_err_not_done", 32'(done_a), 32'd0);
        checkOutput("chk_err_ready_low", 32'(in_ready_a), 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("chk_err_core_rst_low", 32'(core_rst_n_a), 32'd0);
        pulseReload();
        mark_a = wcnt_a;
        mark_b = wcnt_b;
        sendFrame(3, 0);
        checkLoaded("chk_recover");
`else
        x = 8'h00;
        checkOutput("err_tied_low", 32'(err_a | x[0]), 32'd0);
`endif

        // Reset in the middle of a frame, then a full reload from scratch.
        pulseReload();
        applyStimulus(8'h03, 0);
        applyStimulus(8'h00, 0);
        for (int b = 0; b < 5; b++)
            applyStimulus(8'hEE, 0);
        rst_n = 1'b0;
        @(negedge clk);
        checkResetState("midreset");
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        mark_a = wcnt_a;
        mark_b = wcnt_b;
        sendFrame(3, 0);
        checkLoaded("after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
